// File: rtl/sa_credit_ctrl.sv
// ---------------------------------------------------------------------------
// sa_credit_ctrl
//   Credit-based flow control and wormhole locking around a separable switch
//   allocator. Incoming requests are masked by the downstream credit of their
//   (output port, VC) and by any wormhole lock held on the output. Grants from
//   the allocator are screened: only grants matching a live alloc_req are
//   accepted, and at most one per output port (lowest input, then lowest VC).
//   An accepted grant produces a registered input-buffer pop and a crossbar
//   setting one cycle later, consumes one credit and updates the output lock.
//
// Ports
//   clk          : clock, all state updates on the rising edge
//   rst_n        : synchronous reset, active HIGH (1 = reset)
//   req_in       : [PORT][VC] flit waiting at input port i, VC v
//   req_outport  : [PORT][VC][PW] routed output port of that flit
//   req_head     : [PORT][VC] waiting flit is a head flit
//   req_tail     : [PORT][VC] waiting flit is a tail flit
//   alloc_req    : [PORT][VC] credit/lock-gated request to the allocator
//   alloc_grant  : [PORT][VC] combinational grant from the allocator
//   credit_ret   : [PORT][VC] downstream freed one slot of output o, VC v
//   flit_pop     : [PORT][VC] registered one-cycle dequeue pulse
//   xbar_valid   : [PORT] crossbar output o carries a flit this cycle
//   xbar_in_sel  : [PORT][PW] input port driving output o
//   xbar_vc_sel  : [PORT][VW] VC driving output o (also downstream VC)
//   err_flag     : [1:0] sticky; bit0 illegal grant, bit1 credit overflow
// ---------------------------------------------------------------------------
module sa_credit_ctrl #(
    parameter  int PORT_NUM  = 5,
    parameter  int VC_NUM    = 4,
    parameter  int BUF_DEPTH = 4,
    localparam int PW        = $clog2(PORT_NUM),
    localparam int VW        = $clog2(VC_NUM),
    localparam int CW        = $clog2(BUF_DEPTH + 1)
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic [PORT_NUM-1:0][VC_NUM-1:0]         req_in,
    input  logic [PORT_NUM-1:0][VC_NUM-1:0][PW-1:0] req_outport,
    input  logic [PORT_NUM-1:0][VC_NUM-1:0]         req_head,
    input  logic [PORT_NUM-1:0][VC_NUM-1:0]         req_tail,
    output logic [PORT_NUM-1:0][VC_NUM-1:0]         alloc_req,
    input  logic [PORT_NUM-1:0][VC_NUM-1:0]         alloc_grant,
    input  logic [PORT_NUM-1:0][VC_NUM-1:0]         credit_ret,
    output logic [PORT_NUM-1:0][VC_NUM-1:0]         flit_pop,
    output logic [PORT_NUM-1:0]                     xbar_valid,
    output logic [PORT_NUM-1:0][PW-1:0]             xbar_in_sel,
    output logic [PORT_NUM-1:0][VW-1:0]             xbar_vc_sel,
    output logic [1:0]                              err_flag
);

    // Credit counters per (output port, VC)
    logic [PORT_NUM-1:0][VC_NUM-1:0][CW-1:0] credit_q, credit_d;

    // Wormhole lock per output port
    logic [PORT_NUM-1:0]         lock_vld_q, lock_vld_d;
    logic [PORT_NUM-1:0][PW-1:0] lock_in_q,  lock_in_d;
    logic [PORT_NUM-1:0][VW-1:0] lock_vc_q,  lock_vc_d;

    // Registered pop / crossbar outputs
    logic [PORT_NUM-1:0][VC_NUM-1:0] flit_pop_q, flit_pop_d;
    logic [PORT_NUM-1:0]             xbar_valid_q, xbar_valid_d;
    logic [PORT_NUM-1:0][PW-1:0]     xbar_in_sel_q, xbar_in_sel_d;
    logic [PORT_NUM-1:0][VW-1:0]     xbar_vc_sel_q, xbar_vc_sel_d;
    logic [1:0]                      err_flag_q, err_flag_d;

    // Accepted grant per output port (at most one)
    logic [PORT_NUM-1:0]         acc_vld;
    logic [PORT_NUM-1:0][PW-1:0] acc_in;
    logic [PORT_NUM-1:0][VW-1:0] acc_vc;
    logic [PORT_NUM-1:0]         acc_head;
    logic [PORT_NUM-1:0]         acc_tail;
    logic                        err_grant;
    logic                        err_ovf;

    // -----------------------------------------------------------------------
    // Request gating. The credit/lock lookup is done by scanning all outputs
    // for a match, so an out-of-range req_outport simply never requests.
    // -----------------------------------------------------------------------
    always_comb begin
        alloc_req = '0;
        for (int unsigned i = 0; i < PORT_NUM; i++) begin
            for (int unsigned v = 0; v < VC_NUM; v++) begin
                for (int unsigned o = 0; o < PORT_NUM; o++) begin
                    if (!rst_n && req_in[i][v] &&
                        (req_outport[i][v] == PW'(o)) &&
                        (credit_q[o][v] != '0) &&
                        (!lock_vld_q[o] ||
                         ((lock_in_q[o] == PW'(i)) && (lock_vc_q[o] == VW'(v))))) begin
                        alloc_req[i][v] = 1'b1;
                    end
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Grant screening. Scan order (input outer, VC inner) gives the
    // lowest-input-then-lowest-VC priority when several legal grants hit the
    // same output; the losers are flagged as illegal grants.
    // -----------------------------------------------------------------------
    always_comb begin
        acc_vld    = '0;
        acc_in     = '0;
        acc_vc     = '0;
        acc_head   = '0;
        acc_tail   = '0;
        flit_pop_d = '0;
        err_grant  = 1'b0;
        for (int unsigned i = 0; i < PORT_NUM; i++) begin
            for (int unsigned v = 0; v < VC_NUM; v++) begin
                if (alloc_grant[i][v]) begin
                    if (!alloc_req[i][v]) begin
                        err_grant = 1'b1;
                    end else begin
                        for (int unsigned o = 0; o < PORT_NUM; o++) begin
                            if (req_outport[i][v] == PW'(o)) begin
                                if (acc_vld[o]) begin
                                    err_grant = 1'b1;
                                end else begin
                                    acc_vld[o]       = 1'b1;
                                    acc_in[o]        = PW'(i);
                                    acc_vc[o]        = VW'(v);
                                    acc_head[o]      = req_head[i][v];
                                    acc_tail[o]      = req_tail[i][v];
                                    flit_pop_d[i][v] = 1'b1;
                                end
                            end
                        end
                    end
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Credit update: a same-cycle return and consume cancel out. A consume
    // can only come from an accepted grant, which required non-zero credit,
    // so the counter never underflows.
    // -----------------------------------------------------------------------
    always_comb begin
        credit_d = credit_q;
        err_ovf  = 1'b0;
        for (int unsigned o = 0; o < PORT_NUM; o++) begin
            for (int unsigned v = 0; v < VC_NUM; v++) begin
                if (acc_vld[o] && (acc_vc[o] == VW'(v))) begin
                    if (!credit_ret[o][v]) begin
                        credit_d[o][v] = credit_q[o][v] - CW'(1);
                    end
                end else if (credit_ret[o][v]) begin
                    if (credit_q[o][v] == CW'(BUF_DEPTH)) begin
                        err_ovf = 1'b1;
                    end else begin
                        credit_d[o][v] = credit_q[o][v] + CW'(1);
                    end
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Lock update: tail releases (covers single-flit packets), head-only
    // acquires, body flits leave the lock untouched.
    // -----------------------------------------------------------------------
    always_comb begin
        lock_vld_d = lock_vld_q;
        lock_in_d  = lock_in_q;
        lock_vc_d  = lock_vc_q;
        for (int unsigned o = 0; o < PORT_NUM; o++) begin
            if (acc_vld[o]) begin
                if (acc_tail[o]) begin
                    lock_vld_d[o] = 1'b0;
                end else if (acc_head[o]) begin
                    lock_vld_d[o] = 1'b1;
                    lock_in_d[o]  = acc_in[o];
                    lock_vc_d[o]  = acc_vc[o];
                end
            end
        end
    end

    // Crossbar setting and sticky error flags
    always_comb begin
        xbar_valid_d  = acc_vld;
        xbar_in_sel_d = acc_in;
        xbar_vc_sel_d = acc_vc;
        err_flag_d    = err_flag_q | {err_ovf, err_grant};
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            credit_q      <= {(PORT_NUM * VC_NUM){CW'(BUF_DEPTH)}};
            lock_vld_q    <= '0;
            lock_in_q     <= '0;
            lock_vc_q     <= '0;
            flit_pop_q    <= '0;
            xbar_valid_q  <= '0;
            xbar_in_sel_q <= '0;
            xbar_vc_sel_q <= '0;
            err_flag_q    <= '0;
        end else begin
            credit_q      <= credit_d;
            lock_vld_q    <= lock_vld_d;
            lock_in_q     <= lock_in_d;
            lock_vc_q     <= lock_vc_d;
            flit_pop_q    <= flit_pop_d;
            xbar_valid_q  <= xbar_valid_d;
            xbar_in_sel_q <= xbar_in_sel_d;
            xbar_vc_sel_q <= xbar_vc_sel_d;
            err_flag_q    <= err_flag_d;
        end
    end

    assign flit_pop    = flit_pop_q;
    assign xbar_valid  = xbar_valid_q;
    assign xbar_in_sel = xbar_in_sel_q;
    assign xbar_vc_sel = xbar_vc_sel_q;
    assign err_flag    = err_flag_q;

endmodule

// File: tb/tb_sa_credit_ctrl.sv
module tb_sa_credit_ctrl;

    localparam int P  = 5;
    localparam int V  = 4;
    localparam int PW = 3;
    localparam int VW = 2;

    logic                         clk;
    logic                         rst_n;
    logic [P-1:0][V-1:0]          req_in;
    logic [P-1:0][V-1:0][PW-1:0]  req_outport;
    logic [P-1:0][V-1:0]          req_head;
    logic [P-1:0][V-1:0]          req_tail;
    logic [P-1:0][V-1:0]          alloc_req;
    logic [P-1:0][V-1:0]          alloc_grant;
    logic [P-1:0][V-1:0]          credit_ret;
    logic [P-1:0][V-1:0]          flit_pop;
    logic [P-1:0]                 xbar_valid;
    logic [P-1:0][PW-1:0]         xbar_in_sel;
    logic [P-1:0][VW-1:0]         xbar_vc_sel;
    logic [1:0]                   err_flag;

    int n_tests = 0;
    int n_fail  = 0;

    sa_credit_ctrl #(.PORT_NUM(5), .VC_NUM(4), .BUF_DEPTH(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_in      (req_in),
        .req_outport (req_outport),
        .req_head    (req_head),
        .req_tail    (req_tail),
        .alloc_req   (alloc_req),
        .alloc_grant (alloc_grant),
        .credit_ret  (credit_ret),
        .flit_pop    (flit_pop),
        .xbar_valid  (xbar_valid),
        .xbar_in_sel (xbar_in_sel),
        .xbar_vc_sel (xbar_vc_sel),
        .err_flag    (err_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        req_in      = '0;
        req_outport = '0;
        req_head    = '0;
        req_tail    = '0;
        alloc_grant = '0;
        credit_ret  = '0;
    endtask

    // Present a single request (i,v)->o at the negedge
    task automatic put_req(input int i, input int v, input int o, input logic h, input logic t);
        req_in[i][v]      = 1'b1;
        req_outport[i][v] = PW'(o);
        req_head[i][v]    = h;
        req_tail[i][v]    = t;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        rst_n = 1'b1;
        put_req(0, 0, 0, 1'b1, 1'b1);
        @(negedge clk); #1;
        chk("rst_alloc_req_forced0", 32'(alloc_req), 32'h0);
        tick(); tick();

        // ---- reset state ----
        @(negedge clk);
        rst_n = 1'b0;
        idle();
        #1;
        chk("rst_flit_pop",   32'(flit_pop), 32'h0);
        chk("rst_xbar_valid", 32'(xbar_valid), 32'h0);
        chk("rst_in_sel",     32'(xbar_in_sel), 32'h0);
        chk("rst_vc_sel",     32'(xbar_vc_sel), 32'h0);
        chk("rst_err",        32'(err_flag), 32'h0);
        chk("rst_credit32",   32'(dut.credit_q[3][2]), 32'd4);
        chk("rst_lock",       32'(dut.lock_vld_q), 32'h0);
        tick();

        // ---- single-flit packet in1 VC2 -> out3 ----
        @(negedge clk);
        put_req(1, 2, 3, 1'b1, 1'b1);
        #1;
        chk("sf_alloc_req", 32'(alloc_req), 32'h40);
        alloc_grant[1][2] = 1'b1;
        tick();
        chk("sf_flit_pop",   32'(flit_pop), 32'h40);
        chk("sf_xbar_valid", 32'(xbar_valid), 32'h08);
        chk("sf_in_sel",     32'(xbar_in_sel[3]), 32'd1);
        chk("sf_vc_sel",     32'(xbar_vc_sel[3]), 32'd2);
        chk("sf_credit",     32'(dut.credit_q[3][2]), 32'd3);
        chk("sf_nolock",     32'(dut.lock_vld_q), 32'h0);
        @(negedge clk);
        idle();
        tick();
        chk("sf_pop_drop",   32'(flit_pop), 32'h0);
        chk("sf_valid_drop", 32'(xbar_valid), 32'h0);

        // ---- wormhole lock: in0 VC0 3 flits -> out4, in2 VC0 competing ----
        @(negedge clk);
        put_req(0, 0, 4, 1'b1, 1'b0);
        put_req(2, 0, 4, 1'b1, 1'b0);
        #1;
        chk("wh_head_req", 32'(alloc_req), 32'h101);
        alloc_grant[0][0] = 1'b1;
        tick();
        chk("wh_head_pop",  32'(flit_pop), 32'h1);
        chk("wh_lock_set",  32'(dut.lock_vld_q[4]), 32'd1);
        @(negedge clk);
        alloc_grant = '0;
        req_head[0][0] = 1'b0;
        #1;
        chk("wh_body_req_masked", 32'(alloc_req), 32'h001);
        alloc_grant[0][0] = 1'b1;
        tick();
        chk("wh_body_lock_kept", 32'(dut.lock_vld_q[4]), 32'd1);
        @(negedge clk);
        alloc_grant = '0;
        req_tail[0][0] = 1'b1;
        #1;
        chk("wh_tail_req_masked", 32'(alloc_req), 32'h001);
        alloc_grant[0][0] = 1'b1;
        tick();
        chk("wh_tail_lock_clr", 32'(dut.lock_vld_q[4]), 32'd0);
        chk("wh_credit",        32'(dut.credit_q[4][0]), 32'd1);
        @(negedge clk);
        alloc_grant = '0;
        req_in[0][0] = 1'b0;
        req_tail[2][0] = 1'b1;
        #1;
        chk("wh_other_req", 32'(alloc_req), 32'h100);
        alloc_grant[2][0] = 1'b1;
        tick();
        chk("wh_other_pop",    32'(flit_pop), 32'h100);
        chk("wh_other_in_sel", 32'(xbar_in_sel[4]), 32'd2);
        chk("wh_credit0",      32'(dut.credit_q[4][0]), 32'd0);

        // ---- credit exhaustion: in3 VC1 -> out1, 4 grants ----
        @(negedge clk);
        idle();
        put_req(3, 1, 1, 1'b1, 1'b1);
        #1;
        chk("ex_req_first", 32'(alloc_req), 32'h2000);
        alloc_grant[3][1] = 1'b1;
        tick();
        chk("ex_valid", 32'(xbar_valid), 32'h02);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            tick();
        end
        chk("ex_credit0", 32'(dut.credit_q[1][1]), 32'd0);
        @(negedge clk);
        alloc_grant = '0;
        #1;
        chk("ex_masked", 32'(alloc_req), 32'h0);
        credit_ret[1][1] = 1'b1;
        tick();
        chk("ex_credit1", 32'(dut.credit_q[1][1]), 32'd1);
        @(negedge clk);
        credit_ret = '0;
        #1;
        chk("ex_reappear", 32'(alloc_req), 32'h2000);

        // ---- simultaneous return + grant, overflow ----
        @(negedge clk);
        idle();
        put_req(4, 3, 2, 1'b1, 1'b1);
        alloc_grant[4][3] = 1'b1;
        tick();
        @(negedge clk);
        tick();
        chk("rg_credit2", 32'(dut.credit_q[2][3]), 32'd2);
        @(negedge clk);
        credit_ret[2][3] = 1'b1;
        tick();
        chk("rg_pop",        32'(flit_pop), 32'h80000);
        chk("rg_credit_same", 32'(dut.credit_q[2][3]), 32'd2);
        @(negedge clk);
        idle();
        credit_ret[2][3] = 1'b1;
        tick();
        chk("ret_inc", 32'(dut.credit_q[2][3]), 32'd3);
        @(negedge clk);
        idle();
        credit_ret[0][2] = 1'b1;
        tick();
        chk("ovf_credit_sat", 32'(dut.credit_q[0][2]), 32'd4);
        chk("ovf_err",        32'(err_flag), 32'h2);

        // ---- illegal grants ----
        @(negedge clk);
        idle();
        req_outport[0][1] = 3'd0;
        alloc_grant[0][1] = 1'b1;
        #1;
        chk("ill_req_low", 32'(alloc_req), 32'h0);
        tick();
        chk("ill_no_pop",   32'(flit_pop), 32'h0);
        chk("ill_no_valid", 32'(xbar_valid), 32'h0);
        chk("ill_credit",   32'(dut.credit_q[0][1]), 32'd4);
        chk("ill_err",      32'(err_flag), 32'h3);
        @(negedge clk);
        idle();
        put_req(0, 0, 4, 1'b1, 1'b1);
        #1;
        chk("zero_credit_masked", 32'(alloc_req), 32'h0);
        alloc_grant[0][0] = 1'b1;
        tick();
        chk("zero_credit_no_uflow", 32'(dut.credit_q[4][0]), 32'd0);
        chk("zero_credit_no_pop",   32'(flit_pop), 32'h0);
        @(negedge clk);
        idle();
        tick(); tick();
        chk("ill_err_sticky", 32'(err_flag), 32'h3);

        // ---- reset mid-packet with out2 locked ----
        @(negedge clk);
        put_req(1, 0, 2, 1'b1, 1'b0);
        alloc_grant[1][0] = 1'b1;
        tick();
        chk("mp_lock_set", 32'(dut.lock_vld_q[2]), 32'd1);
        chk("mp_lock_in",  32'(dut.lock_in_q[2]), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        req_head[1][0] = 1'b0;
        #1;
        chk("mp_rst_req0", 32'(alloc_req), 32'h0);
        tick();
        chk("mp_lock_clr",  32'(dut.lock_vld_q), 32'h0);
        chk("mp_no_pop",    32'(flit_pop), 32'h0);
        chk("mp_no_valid",  32'(xbar_valid), 32'h0);
        chk("mp_err_clr",   32'(err_flag), 32'h0);
        chk("mp_credit20",  32'(dut.credit_q[2][0]), 32'd4);
        chk("mp_credit40",  32'(dut.credit_q[4][0]), 32'd4);
        @(negedge clk);
        rst_n = 1'b0;
        idle();
        tick();
        chk("mp_post_no_pop", 32'(flit_pop), 32'h0);

        // ---- multiple legal grants to one output ----
        @(negedge clk);
        put_req(3, 0, 0, 1'b1, 1'b1);
        put_req(1, 2, 0, 1'b1, 1'b1);
        #1;
        chk("mg_req", 32'(alloc_req), 32'h1040);
        alloc_grant[3][0] = 1'b1;
        alloc_grant[1][2] = 1'b1;
        tick();
        chk("mg_pop",       32'(flit_pop), 32'h40);
        chk("mg_in_sel",    32'(xbar_in_sel[0]), 32'd1);
        chk("mg_vc_sel",    32'(xbar_vc_sel[0]), 32'd2);
        chk("mg_err",       32'(err_flag), 32'h1);
        chk("mg_credit_w",  32'(dut.credit_q[0][2]), 32'd3);
        chk("mg_credit_l",  32'(dut.credit_q[0][0]), 32'd4);
        @(negedge clk);
        idle();
        put_req(2, 3, 1, 1'b1, 1'b1);
        put_req(2, 1, 1, 1'b1, 1'b1);
        alloc_grant[2][3] = 1'b1;
        alloc_grant[2][1] = 1'b1;
        tick();
        chk("mg_vc_pop",    32'(flit_pop), 32'h200);
        chk("mg_vc_sel_lo", 32'(xbar_vc_sel[1]), 32'd1);
        @(negedge clk);
        idle();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
